// File: rtl/dds_sweep_ctrl.sv
// Frequency/phase word sequencer for the DDS core: linear sweeps from k_start to
// k_stop with a per-word dwell, in single, repeat or triangle mode.
module dds_sweep_ctrl #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [KW-1:0] k_start,
  input  logic [KW-1:0] k_stop,
  input  logic [KW-1:0] k_step,
  input  logic [DW-1:0] dwell,
  input  logic [PW-1:0] phase,
  input  logic [1:0]    mode,
  output logic [KW-1:0] k_out,
  output logic [PW-1:0] p_out,
  output logic          busy,
  output logic          done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] M_REPEAT   = 2'b01;
  localparam logic [1:0] M_TRIANGLE = 2'b10;

  logic [0:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] p_q, p_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [KW-1:0] kstart_q, kstart_d;
  logic [KW-1:0] kstop_q, kstop_d;
  logic [KW-1:0] step_q, step_d;
  logic [KW-1:0] tgt_q, tgt_d;
  logic          up_q, up_d;
  logic [1:0]    mode_q, mode_d;
  logic [KW-1:0] swap_tgt;

  // One step toward tgt, clamped; the extra bit catches overflow/underflow.
  function automatic logic [KW-1:0] step_toward(input logic [KW-1:0] k,
                                                input logic [KW-1:0] tgt,
                                                input logic          up,
                                                input logic [KW-1:0] stp);
    logic [KW:0] sum;
    if (up) begin
      sum = {1'b0, k} + {1'b0, stp};
      step_toward = (sum > {1'b0, tgt}) ? tgt : sum[KW-1:0];
    end else begin
      sum = {1'b0, k} - {1'b0, stp};
      step_toward = (sum[KW] || (sum[KW-1:0] < tgt)) ? tgt : sum[KW-1:0];
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    p_d      = p_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    kstart_d = kstart_q;
    kstop_d  = kstop_q;
    step_d   = step_q;
    tgt_d    = tgt_q;
    up_d     = up_q;
    mode_d   = mode_q;
    swap_tgt = (tgt_q == kstop_q) ? kstart_q : kstop_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          k_d      = k_start;
          p_d      = phase;
          busy_d   = 1'b1;
          cnt_d    = '0;
          dwell_d  = dwell;
          kstart_d = k_start;
          kstop_d  = k_stop;
          step_d   = (k_step == '0) ? {{(KW-1){1'b0}}, 1'b1} : k_step;
          tgt_d    = k_stop;
          up_d     = (k_stop >= k_start);
          mode_d   = mode;
        end
      end
      default: begin
        if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (k_q != tgt_q) begin
            k_d = step_toward(k_q, tgt_q, up_q, step_q);
          end else begin
            case (mode_q)
              M_REPEAT: k_d = kstart_q;
              M_TRIANGLE: begin
                // Turn around and take the first step of the return leg now.
                tgt_d = swap_tgt;
                up_d  = ~up_q;
                k_d   = step_toward(k_q, swap_tgt, ~up_q, step_q);
              end
              default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      p_d     = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      kstart_q <= '0;
      kstop_q  <= '0;
      step_q   <= '0;
      tgt_q    <= '0;
      up_q     <= 1'b0;
      mode_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      kstart_q <= kstart_d;
      kstop_q  <= kstop_d;
      step_q   <= step_d;
      tgt_q    <= tgt_d;
      up_q     <= up_d;
      mode_q   <= mode_d;
    end
  end

  assign k_out = k_q;
  assign p_out = p_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: per-sweep word-list model checked every cycle,
// plus literal sequences from hand-worked sweeps and randomized sweeps.
module tb_dds_sweep_ctrl;
  localparam int KW = 32;
  localparam int PW = 11;
  localparam int DW = 16;

  logic          clk, rst_n, start, abort;
  logic [KW-1:0] k_start, k_stop, k_step;
  logic [DW-1:0] dwell;
  logic [PW-1:0] phase;
  logic [1:0]    mode;
  logic [KW-1:0] k_out;
  logic [PW-1:0] p_out;
  logic          busy, done;

  int total = 0;
  int bad   = 0;

  dds_sweep_ctrl #(.KW(KW), .PW(PW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .k_start(k_start), .k_stop(k_stop), .k_step(k_step), .dwell(dwell),
    .phase(phase), .mode(mode), .k_out(k_out), .p_out(p_out),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: at start the whole pass is expanded into a queue of per-cycle words.
  longint    q[$];
  longint    m_k, m_a, m_b, m_s;
  int        m_d;
  logic [PW-1:0] m_p;
  logic [1:0] m_mode;
  bit        m_busy, m_done, m_run, m_fwd;

  task automatic add_pass(input longint a, input longint b, input bit skip_first);
    longint w;
    bit     first, fin;
    w = a; first = 1; fin = 0;
    while (!fin) begin
      if (!(skip_first && first && a != b))
        repeat (m_d + 1) q.push_back(w);
      first = 0;
      if (w == b) fin = 1;
      else if (b >= a) w = (w + m_s > b) ? b : w + m_s;
      else w = (w - m_s < b) ? b : w - m_s;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_p = '0; m_busy = 0; m_done = 0; m_run = 0; q.delete();
    end else begin
      m_done = 0;
      if (abort) begin
        m_k = 0; m_p = '0; m_busy = 0; m_run = 0; q.delete();
      end else if (m_run) begin
        if (q.size() == 0) begin
          if (m_mode == 2'b01) add_pass(m_a, m_b, 0);
          else if (m_mode == 2'b10) begin
            m_fwd = !m_fwd;
            if (m_fwd) add_pass(m_a, m_b, 1);
            else add_pass(m_b, m_a, 1);
          end else begin
            m_run = 0; m_busy = 0; m_done = 1;
          end
        end
        if (q.size() > 0) m_k = q.pop_front();
      end else if (start) begin
        m_a = longint'(k_start); m_b = longint'(k_stop);
        m_s = (k_step == 0) ? 1 : longint'(k_step);
        m_d = int'(dwell); m_mode = mode; m_p = phase;
        m_run = 1; m_busy = 1; m_fwd = 1;
        q.delete();
        add_pass(m_a, m_b, 0);
        m_k = q.pop_front();
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      total++;
      if (longint'(k_out) != m_k || p_out !== m_p || busy !== m_busy || done !== m_done) begin
        bad++;
        $display("FAIL model t=%0t got k=%0d p=%0h busy=%0b done=%0b want k=%0d p=%0h busy=%0b done=%0b",
                 $time, k_out, p_out, busy, done, m_k, m_p, m_busy, m_done);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] md, input logic [KW-1:0] ks, input logic [KW-1:0] ke,
                          input logic [KW-1:0] st, input logic [DW-1:0] dw, input logic [PW-1:0] ph);
    @(negedge clk);
    mode = md; k_start = ks; k_stop = ke; k_step = st; dwell = dw; phase = ph; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask

  longint lit[];

  // Checks k_out against lit[] from the first cycle after start, then either
  // the done pulse (single) or an abort landing on zero.
  task automatic run_lit(input string nm, input bit single, input bit poke, input logic [PW-1:0] ph);
    for (int i = 0; i < lit.size(); i++) begin
      chk({nm, "_k"}, longint'(k_out), lit[i]);
      if (poke) chk({nm, "_p"}, longint'(p_out), longint'(ph));
      if (poke && i == 2) begin
        start = 1; k_start = 500; k_stop = 900; phase = 0;
      end else start = 0;
      @(negedge clk);
    end
    start = 0;
    if (single) begin
      chk({nm, "_done"}, longint'(done), 1);
      chk({nm, "_busy"}, longint'(busy), 0);
      chk({nm, "_khold"}, longint'(k_out), lit[lit.size()-1]);
      @(negedge clk);
      chk({nm, "_done_clr"}, longint'(done), 0);
    end else begin
      do_abort();
      chk({nm, "_abort_k"}, longint'(k_out), 0);
      chk({nm, "_abort_p"}, longint'(p_out), 0);
      chk({nm, "_abort_busy"}, longint'(busy), 0);
    end
  endtask

  task automatic wait_idle(input bit poke);
    int c = 0;
    while (busy && c < 3000) begin
      if (poke && $urandom_range(0, 7) == 0) begin
        start = 1; k_start = $urandom; k_stop = $urandom; k_step = $urandom;
        dwell = DW'($urandom); mode = 2'($urandom); phase = PW'($urandom);
      end else start = 0;
      @(negedge clk);
      c++;
    end
    start = 0;
    chk("idle_bound", longint'(busy), 0);
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; k_start = 0; k_stop = 0; k_step = 0;
    dwell = 0; phase = 0; mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_k", longint'(k_out), 0);
    chk("rst_p", longint'(p_out), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    rst_n = 1;
    @(negedge clk);

    do_start(2'b00, 100, 130, 10, 2, 11'h055);
    lit = '{100,100,100,110,110,110,120,120,120,130,130,130};
    run_lit("up_single", 1, 0, 0);

    do_start(2'b00, 100, 125, 10, 0, 0);
    lit = '{100,110,120,125};
    run_lit("clamp", 1, 0, 0);

    do_start(2'b11, 50, 20, 15, 0, 0);
    lit = '{50,35,20};
    run_lit("down", 1, 0, 0);

    do_start(2'b10, 0, 20, 10, 0, 11'h123);
    lit = '{0,10,20,10,0,10,20,10};
    run_lit("triangle", 0, 0, 0);

    do_start(2'b01, 0, 20, 10, 0, 11'h3FF);
    lit = '{0,10,20,0,10,20,0};
    run_lit("repeat", 0, 1, 11'h3FF);

    do_start(2'b00, 5, 7, 0, 0, 0);
    lit = '{5,6,7};
    run_lit("step0", 1, 0, 0);

    do_start(2'b00, 9, 9, 4, 3, 0);
    lit = '{9,9,9,9};
    run_lit("flat", 1, 0, 0);

    do_start(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 0);
    lit = '{64'hFFFF_FFF0, 64'hFFFF_FFFF};
    run_lit("nowrap_up", 1, 0, 0);

    do_start(2'b00, 32'h10, 0, 32'h20, 0, 0);
    lit = '{16, 0};
    run_lit("nowrap_dn", 1, 0, 0);

    @(negedge clk);
    start = 1; abort = 1; k_start = 77; k_stop = 99; k_step = 1; mode = 0;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort_busy", longint'(busy), 0);
    chk("start_abort_k", longint'(k_out), 0);

    for (int it = 0; it < 40; it++) begin
      logic [KW-1:0] base;
      logic [1:0] md;
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0;
      md = 2'($urandom_range(0, 3));
      do_start(md, base + $urandom_range(0, 250), base + $urandom_range(0, 250),
               $urandom_range(0, 60), DW'($urandom_range(0, 3)), PW'($urandom));
      if (md == 2'b01 || md == 2'b10) begin
        repeat ($urandom_range(10, 120)) begin
          start = ($urandom_range(0, 7) == 0);
          k_start = $urandom; phase = PW'($urandom);
          @(negedge clk);
        end
        start = 0;
        do_abort();
      end else begin
        wait_idle(1);
        @(negedge clk);
      end
    end

    do_start(2'b00, 1000, 2000, 3, 1, 11'h7AA);
    repeat (7) @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("async_rst_k", longint'(k_out), 0);
    chk("async_rst_p", longint'(p_out), 0);
    chk("async_rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", longint'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
endmodule
